aes_key_schedule_seq: RTL and testbench
=======================================

// Module: aes_key_schedule_seq
//
// PURPOSE
// Sequential, parametrised AES key-expansion engine that supports AES-128, AES-192 and AES-256.
// It computes one 32-bit schedule word per clock and stores the full schedule in an internal register file.
// The round datapath then reads any round key, 128 bits wide, by round index.
// It replaces per-round combinational key prediction: it precomputes all round keys once per key load.
//
// PARAMETERS
// KEY_BITS  128  cipher key length; legal values 128/192/256, anything else is a synthesis error
// NK        KEY_BITS/32  (derived, localparam) key length in words: 4/6/8
// NR        NK+6  (derived, localparam) number of rounds: 10/12/14
// TOTAL     4*(NR+1)  (derived, localparam) schedule words: 44/52/60
//
// PORTS
// clk        in   1          system clock, rising edge
// n_rst      in   1          asynchronous, active-low reset
// start      in   1          load key_in and begin expansion; sampled only in IDLE or DONE
// key_in     in   KEY_BITS   cipher key; word 0 = key_in[KEY_BITS-1 -: 32]
// busy       out  1          high while expansion is in progress
// done       out  1          one-cycle pulse when the final schedule word is written
// keys_valid out  1          high from done until the next accepted start or reset
// rd_idx     in   4          round-key index, 0..NR
// rd_key     out  128        round key rd_idx = {w[4r],w[4r+1],w[4r+2],w[4r+3]}; combinational read
//
// BEHAVIOUR
// - Reset (n_rst low, asynchronous): state=IDLE; busy=0, done=0, keys_valid=0; word counter=0; all words=0.
// - FSM states: IDLE -> EXPAND -> DONE. DONE -> EXPAND on start; DONE is otherwise held.
// - Start edge E0 (start=1 in IDLE or DONE):
//   - w[0..NK-1] <= key_in; i <= NK; rcon <= 8'h01.
//   - busy=1, keys_valid=0 starting the cycle after E0.
// - EXPAND, one word per edge, with t = w[i-1]:
//   - if i%NK==0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon <= xtime(rcon).
//   - else if NK==8 and i%NK==4: t = SubWord(t).
//   - w[i] <= w[i-NK] ^ t; i <= i+1.
// - RotWord is a 1-byte left rotate. SubWord applies the FIPS-197 S-box to each byte (4 parallel lookups).
// - xtime is a GF(2^8) doubling: 80 -> 1B, 1B -> 36.
// - Final word w[TOTAL-1] is written at edge E0+(TOTAL-NK), i.e. edge 40/46/52 for KEY_BITS 128/192/256:
//   - The FSM moves to DONE.
//   - done=1 for exactly that one cycle; keys_valid=1; busy=0.
// - start while busy=1 is ignored; no restart and no error.
// - start in DONE restarts: keys_valid drops immediately on the next cycle.
//   The old schedule is not readable during re-expansion.
// - rd_key = 128'h0 whenever keys_valid=0 or rd_idx>NR; otherwise it is a pure combinational read.
// - Reset asserted mid-EXPAND aborts immediately. After release the block sits in IDLE with keys_valid=0.
// - key_in needs to be stable only on the start edge; later changes have no effect.
//
// TESTING
// - AES-128 key 2b7e151628aed2a6abf7158809cf4f3c:
//   done exactly 40 edges after start; rd_idx=1 -> a0fafe1788542cb123a339392a6c7605;
//   rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
// - AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
//   done after 46 edges; rd_idx=12 -> e98ba06f448c773c8ecc720401002202.
// - AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
//   done after 52 edges; rd_idx=14 -> fe4890d1e6188d0b046df344706c631e.
// - start pulsed again mid-EXPAND with a different key:
//   ignored; the first key's schedule completes unchanged and done pulses once.
// - n_rst low at edge 20 of EXPAND:
//   busy/done/keys_valid=0 and rd_key=0.
//   A fresh start then yields the correct schedule with full latency.
// - With keys_valid=1:
//   rd_idx=NR+1 (e.g. 11 for AES-128) -> rd_key=0.
//   A restart in DONE drops keys_valid the next cycle; done follows 40 edges later.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock into a register file,
// with a combinational 128-bit round-key read port indexed by round.
module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                done,
    output logic                keys_valid,
    input  logic [3:0]          rd_idx,
    output logic [127:0]        rd_key
);

    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);

    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);
    localparam logic [2:0] NK_LAST  = 3'(NK - 1);
    localparam logic [3:0] NR_IDX   = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  j_q, j_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        kv_q, kv_d;
    logic [31:0] w_q [TOTAL];
    logic [31:0] w_d [TOTAL];

    logic [31:0] t_prev, t_mix, new_word;
    logic [5:0]  rd_base;

    // j tracks i mod NK so the NK=6 case needs no divider.
    always_comb begin
        t_prev = w_q[i_q - 6'd1];
        if (j_q == 3'd0) begin
            t_mix = sub_word({t_prev[23:0], t_prev[31:24]}) ^ {rcon_q, 24'h0};
        end else if (NK == 8 && j_q == 3'd4) begin
            t_mix = sub_word(t_prev);
        end else begin
            t_mix = t_prev;
        end
        new_word = w_q[i_q - NK_W] ^ t_mix;
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        w_d     = w_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    for (int unsigned k = 0; k < NK; k++) begin
                        w_d[k] = key_in[KEY_BITS-1-32*k -: 32];
                    end
                    i_d     = NK_W;
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + 6'd1;
                j_d      = (j_q == NK_LAST) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            for (int unsigned k = 0; k < TOTAL; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        rd_base = {rd_idx, 2'b00};
        rd_key  = '0;
        if (kv_q && rd_idx <= NR_IDX) begin
            rd_key = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: one instance per key size, FIPS-197 round keys,
// latency, ignored mid-expansion start, reset abort and restart from DONE.
module tb_aes_key_schedule_seq;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   rd_idx = '0;
    logic [127:0] key128 = K128;
    logic [191:0] key192 = K192;
    logic [255:0] key256 = K256;
    logic         busy_o [3];
    logic         done_o [3];
    logic         kv_o   [3];
    logic [127:0] rk_o   [3];

    int total = 0;
    int bad   = 0;
    int lat    [3];
    int npulse [3];
    int exp_lat [3] = '{40, 46, 52};

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.KEY_BITS(128)) u_128 (
        .clk(clk), .n_rst(n_rst), .start(start), .key_in(key128),
        .busy(busy_o[0]), .done(done_o[0]), .keys_valid(kv_o[0]),
        .rd_idx(rd_idx), .rd_key(rk_o[0]));

    aes_key_schedule_seq #(.KEY_BITS(192)) u_192 (
        .clk(clk), .n_rst(n_rst), .start(start), .key_in(key192),
        .busy(busy_o[1]), .done(done_o[1]), .keys_valid(kv_o[1]),
        .rd_idx(rd_idx), .rd_key(rk_o[1]));

    aes_key_schedule_seq #(.KEY_BITS(256)) u_256 (
        .clk(clk), .n_rst(n_rst), .start(start), .key_in(key256),
        .busy(busy_o[2]), .done(done_o[2]), .keys_valid(kv_o[2]),
        .rd_idx(rd_idx), .rd_key(rk_o[2]));

    typedef struct {
        int           sel;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < 14; k++) begin
            rd_idx = vecs[k].idx;
            #1;
            chk($sformatf("%s_rd%0d_dut%0d_idx%0d", tag, k, vecs[k].sel, vecs[k].idx),
                rk_o[vecs[k].sel], vecs[k].exp);
        end
        rd_idx = '0;
    endtask

    // restart_at: cycle to pulse start with a scrambled key; abort_at: cycle to pulse reset.
    task automatic run_all(input string tag, input int restart_at, input int abort_at);
        bit aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_busy_e0_dut%0d", tag, d), 128'(busy_o[d]), 128'd1);
            chk($sformatf("%s_kv_e0_dut%0d", tag, d), 128'(kv_o[d]), 128'd0);
            chk($sformatf("%s_rdkey_e0_dut%0d", tag, d), rk_o[d], 128'd0);
            lat[d]    = -1;
            npulse[d] = 0;
        end
        for (int cyc = 1; cyc <= 80 && !aborted; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (done_o[d] === 1'b1) begin
                    npulse[d]++;
                    if (lat[d] < 0) lat[d] = cyc;
                end
            end
            if (cyc == restart_at) begin
                key128 = ~K128;
                key192 = ~K192;
                key256 = ~K256;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cyc == abort_at) begin
                n_rst = 1'b0;
                #1;
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("%s_rst_busy_dut%0d", tag, d), 128'(busy_o[d]), 128'd0);
                    chk($sformatf("%s_rst_done_dut%0d", tag, d), 128'(done_o[d]), 128'd0);
                    chk($sformatf("%s_rst_kv_dut%0d", tag, d), 128'(kv_o[d]), 128'd0);
                    chk($sformatf("%s_rst_rdkey_dut%0d", tag, d), rk_o[d], 128'd0);
                end
                @(negedge clk);
                n_rst = 1'b1;
                repeat (3) @(negedge clk);
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("%s_post_rst_kv_dut%0d", tag, d), 128'(kv_o[d]), 128'd0);
                    chk($sformatf("%s_post_rst_busy_dut%0d", tag, d), 128'(busy_o[d]), 128'd0);
                end
                aborted = 1'b1;
            end
        end
        start  = 1'b0;
        key128 = K128;
        key192 = K192;
        key256 = K256;
        if (!aborted) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s_latency_dut%0d", tag, d), 128'(lat[d]), 128'(exp_lat[d]));
                chk($sformatf("%s_done_pulses_dut%0d", tag, d), 128'(npulse[d]), 128'd1);
                chk($sformatf("%s_kv_end_dut%0d", tag, d), 128'(kv_o[d]), 128'd1);
                chk($sformatf("%s_busy_end_dut%0d", tag, d), 128'(busy_o[d]), 128'd0);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4]  = '{0, 4'd11, 128'h0};
        vecs[5]  = '{0, 4'd15, 128'h0};
        vecs[6]  = '{1, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[7]  = '{1, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[8]  = '{1, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[9]  = '{1, 4'd13, 128'h0};
        vecs[10] = '{2, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[11] = '{2, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a};
        vecs[12] = '{2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[13] = '{2, 4'd15, 128'h0};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_busy_dut%0d", d), 128'(busy_o[d]), 128'd0);
            chk($sformatf("reset_done_dut%0d", d), 128'(done_o[d]), 128'd0);
            chk($sformatf("reset_kv_dut%0d", d), 128'(kv_o[d]), 128'd0);
            chk($sformatf("reset_rdkey_dut%0d", d), rk_o[d], 128'd0);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_all("first", -1, -1);
        check_reads("first");

        run_all("ignored_start", 10, -1);
        check_reads("ignored_start");

        run_all("abort", -1, 20);
        run_all("fresh", -1, -1);
        check_reads("fresh");

        run_all("restart_done", -1, -1);
        check_reads("restart_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
